testport_write_capture: RTL

//  Sits between the CPU data-memory write bus and the result checker. Snoops

---
 rtl/testport_defs.sv | 19 +
 rtl/sync_fifo.sv | 48 ++++
 rtl/testport_write_capture.sv | 132 +++++++++++++
 3 files changed

// File: rtl/testport_defs.sv
// rtl/testport_defs.sv - shared constants, state encoding and byteswap helper for testport_write_capture
package testport_defs;

    localparam logic [29:0] TEST_PORT    = 30'h10;
    localparam logic [31:0] BEGIN_SYMBOL = 32'h00000168;
    localparam logic [31:0] END_SYMBOL   = 32'hFFFFFD5D;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_STREAM = 2'd1,
        ST_DONE   = 2'd2
    } state_t;

    // Little-endian bus word to readable (big-endian) order.
    function automatic logic [31:0] byteswap32(input logic [31:0] d);
        return {d[7:0], d[15:8], d[23:16], d[31:24]};
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - single-clock FIFO with extra-MSB pointers and registered head word
module sync_fifo #(
    parameter int WIDTH = 33,
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic             accepted,
    output logic             full,
    output logic             empty,
    output logic [WIDTH-1:0] head_data
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic [WIDTH-1:0] mem [DEPTH];
    logic             do_pop;

    assign empty    = (wr_ptr == rd_ptr);
    assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_pop   = pop && !empty;
    // A full FIFO still takes a push when the head leaves in the same cycle.
    assign accepted = push && (!full || do_pop);
    // Head reads as zero while empty so the outputs are clean out of reset.
    assign head_data = empty ? '0 : mem[rd_ptr[AW-1:0]];

    // Pointer update; wraps naturally modulo 2*DEPTH.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (accepted) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)   rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // Storage write; contents need no reset because empty masks them.
    always_ff @(posedge clk) begin
        if (accepted) mem[wr_ptr[AW-1:0]] <= push_data;
    end

endmodule

// File: rtl/testport_write_capture.sv
// rtl/testport_write_capture.sv - test-port write snooper and frame capture; optional watchdog via CAPTURE_TIMEOUT_EN
module testport_write_capture
    import testport_defs::*;
#(
    parameter int DEPTH          = 8,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [29:0] addr,
    input  logic [31:0] data,
    input  logic        wen,
    input  logic        out_ready,
    output logic        out_valid,
    output logic [31:0] out_data,
    output logic        out_last,
    output logic        frame_active,
    output logic        overflow,
    output logic        timeout,
    output logic [7:0]  word_count
);

    state_t      state, state_nxt;
    logic        wen_d;
    logic        qw;
    logic [31:0] w;
    logic        is_end;
    logic        fifo_push;
    logic        accepted;
    logic        fifo_full;
    logic        fifo_empty;
    logic [32:0] head;
    logic        tmo_hit;

    // A stalled store holds wen high; only its first cycle counts.
    assign qw     = (addr == TEST_PORT) && wen && !wen_d;
    assign w      = byteswap32(data);
    assign is_end = (w == END_SYMBOL);

`ifdef CAPTURE_TIMEOUT_EN
    localparam int TCW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TCW-1:0] idle_cnt;

    assign tmo_hit = (state == ST_STREAM) && (idle_cnt == TCW'(TIMEOUT_CYCLES));

    // Idle watchdog: restarts on every qualified write and outside STREAM.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            idle_cnt <= '0;
        end else if (state != ST_STREAM || qw) begin
            idle_cnt <= '0;
        end else if (!tmo_hit) begin
            idle_cnt <= idle_cnt + 1'b1;
        end
    end

    // Sticky timeout flag.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)         timeout <= 1'b0;
        else if (tmo_hit) timeout <= 1'b1;
    end
`else
    assign tmo_hit = 1'b0;
    assign timeout = 1'b0;
`endif

    // State register and write-enable history.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= ST_IDLE;
            wen_d <= 1'b0;
        end else begin
            state <= state_nxt;
            wen_d <= wen;
        end
    end

    // Frame sequencing: Begin opens, End (kept or dropped) or watchdog closes.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:   if (qw && w == BEGIN_SYMBOL) state_nxt = ST_STREAM;
            ST_STREAM: if (tmo_hit || (qw && is_end)) state_nxt = ST_DONE;
            ST_DONE:   state_nxt = ST_DONE;
            default:   state_nxt = ST_IDLE;
        endcase
    end

    // Per-state outputs: only STREAM writes reach the FIFO.
    always_comb begin
        fifo_push    = 1'b0;
        frame_active = 1'b0;
        if (state == ST_STREAM) begin
            frame_active = 1'b1;
            fifo_push    = qw && !tmo_hit;
        end
    end

    // Accepted-word counter and sticky overflow.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            word_count <= 8'd0;
            overflow   <= 1'b0;
        end else begin
            if (accepted && word_count != 8'hFF) word_count <= word_count + 8'd1;
            if (fifo_push && !accepted)          overflow   <= 1'b1;
        end
    end

    sync_fifo #(
        .WIDTH (33),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (fifo_push),
        .push_data ({is_end, w}),
        .pop       (out_ready),
        .accepted  (accepted),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .head_data (head)
    );

    assign out_valid = !fifo_empty;
    assign out_data  = head[31:0];
    assign out_last  = head[32];

    logic unused_full;
    assign unused_full = fifo_full;

endmodule
